// File: rtl/store_buffer.sv
// In-order store buffer between the pipeline's committed stores and the DCache write port.
// Optional write-merging into the youngest entry is enabled by defining STORE_MERGE_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [1:0]               st_size,
  input  logic [31:0]              st_data,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  output logic [3:0]               wr_wstrb,
  output logic [31:0]              wr_data,
  input  logic                     wr_addr_ok,
  input  logic                     wr_data_ok,
  input  logic                     ld_check,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_next;
  logic [29:0]     ent_addr [DEPTH];
  logic [3:0]      ent_strb [DEPTH];
  logic [31:0]     ent_data [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            full, push, pop, merge;
  logic [3:0]      fmt_strb;
  logic [31:0]     fmt_data;
  logic            conflict_hit;
  logic            unused_ld;

  assign unused_ld = ^ld_addr[1:0];

  always_comb begin
    fmt_strb = 4'b1111;
    fmt_data = st_data;
    case (st_size)
      2'd0: begin
        fmt_strb = 4'b0001 << st_addr[1:0];
        fmt_data = {4{st_data[7:0]}};
      end
      2'd1: begin
        fmt_strb = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign full = (count == CW'(DEPTH));
  assign pop  = (state == WAIT) && wr_data_ok;

`ifdef STORE_MERGE_EN
  logic [PW-1:0] young;
  logic          locked, merge_hit;

  // The youngest entry is only the in-flight head when it is the sole entry.
  assign young     = tail - PW'(1);
  assign locked    = (count == CW'(1)) && (state != IDLE);
  assign merge_hit = (count != '0) && !locked && (ent_addr[young] == st_addr[31:2]);
  assign st_ready  = !full || merge_hit;
  assign merge     = st_valid && merge_hit;
  assign push      = st_valid && st_ready && !merge_hit;
`else
  assign st_ready  = !full;
  assign merge     = 1'b0;
  assign push      = st_valid && !full;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[31:2];
      ent_strb[tail] <= fmt_strb;
      ent_data[tail] <= fmt_data;
    end
`ifdef STORE_MERGE_EN
    if (merge) begin
      ent_strb[young] <= ent_strb[young] | fmt_strb;
      for (int unsigned b = 0; b < 4; b++) begin
        if (fmt_strb[b]) ent_data[young][8*b +: 8] <= fmt_data[8*b +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    case (state)
      IDLE: if (count != '0) state_next = REQ;
      REQ: begin
        wr_req = 1'b1;
        if (wr_addr_ok) state_next = WAIT;
      end
      WAIT: if (wr_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload is forced to zero while empty so stale entries never show on the port.
  assign sb_empty = (count == '0);
  assign sb_count = count;
  assign wr_addr  = sb_empty ? '0 : {ent_addr[head], 2'b00};
  assign wr_wstrb = sb_empty ? '0 : ent_strb[head];
  assign wr_data  = sb_empty ? '0 : ent_data[head];

  always_comb begin
    logic [PW-1:0] idx;
    conflict_hit = 1'b0;
    idx          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == ld_addr[31:2])) conflict_hit = 1'b1;
    end
  end

  assign ld_conflict = ld_check && conflict_hit;

  // merge is only consumed when STORE_MERGE_EN is defined
  logic unused_merge;
  assign unused_merge = merge;

endmodule
